// File: rtl/decode_stage_v2_pkg.sv
// rtl/decode_stage_v2_pkg.sv - shared encodings, field slices and immediate helpers for the decode stage
package decode_stage_v2_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;

    localparam int IMM_SEL_WIDTH = 3;
    localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_I = 3'd0;
    localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_S = 3'd1;
    localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_B = 3'd2;
    localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_J = 3'd3;
    localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_U = 3'd4;

    localparam int BRANCH_OP_WIDTH = 3;
    localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_EQ  = 3'd0;
    localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_NE  = 3'd1;
    localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_LT  = 3'd4;
    localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_GE  = 3'd5;
    localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_LTU = 3'd6;
    localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_GEU = 3'd7;

    localparam int FORWARD_SEL_WIDTH = 2;
    localparam logic [FORWARD_SEL_WIDTH-1:0] FORWARD_SEL_EXE = 2'd0;
    localparam logic [FORWARD_SEL_WIDTH-1:0] FORWARD_SEL_MEM = 2'd1;
    localparam logic [FORWARD_SEL_WIDTH-1:0] FORWARD_SEL_WB  = 2'd2;

    localparam logic [31:0] BUBBLE_INSTR_DEFAULT = 32'h0000_0013;

    function automatic reg_idx_t rs1_of(input logic [31:0] i);
        return i[RS1_LSB +: REG_IDX_W];
    endfunction

    function automatic reg_idx_t rs2_of(input logic [31:0] i);
        return i[RS2_LSB +: REG_IDX_W];
    endfunction

    function automatic reg_idx_t rd_of(input logic [31:0] i);
        return i[RD_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    // Unknown selects decode as I-type so a bad control word still yields a defined value.
    function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [IMM_SEL_WIDTH-1:0] sel);
        case (sel)
            IMM_SEL_S: return imm_s(i);
            IMM_SEL_B: return imm_b(i);
            IMM_SEL_J: return imm_j(i);
            IMM_SEL_U: return imm_u(i);
            default:   return imm_i(i);
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_v2_if.sv
// rtl/decode_stage_v2_if.sv - IF/ID input and ID/EX output handshake bundle of the decode stage
interface decode_stage_v2_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [31:0]     out_instr;
    logic [4:0]      out_rs1_addr;
    logic [4:0]      out_rs2_addr;
    logic [4:0]      out_rd_addr;
    logic            out_illegal_reg;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_instr, out_rs1_addr, out_rs2_addr, out_rd_addr, out_illegal_reg
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_instr, out_rs1_addr, out_rs2_addr, out_rd_addr, out_illegal_reg
    );

endinterface

// File: rtl/decode_stage_v2_branch.sv
// rtl/decode_stage_v2_branch.sv - branch condition comparator
module branch_comp
    import decode_stage_v2_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [BRANCH_OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]            a,
    input  logic [XLEN-1:0]            b,
    output logic                       taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BRANCH_OP_EQ:  taken = (a == b);
            BRANCH_OP_NE:  taken = (a != b);
            BRANCH_OP_LT:  taken = ($signed(a) <  $signed(b));
            BRANCH_OP_GE:  taken = ($signed(a) >= $signed(b));
            BRANCH_OP_LTU: taken = (a <  b);
            BRANCH_OP_GEU: taken = (a >= b);
            default:       taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_stage_v2_regfile.sv
// rtl/decode_stage_v2_regfile.sv - parametrised 2R1W register file with same-cycle write bypass
module regfile_param #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    localparam int RA_W = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_ok;

    assign wr_ok = we && (wa != 5'd0) && (32'(wa) < NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wa[RA_W-1:0]] <= wd;
        end
    end

    // x0 and indices beyond the configured file read as zero, ahead of the bypass.
    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0 && 32'(ra1) < NUM_REGS)
            rd1 = (we && wa == ra1) ? wd : regs[ra1[RA_W-1:0]];
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != 5'd0 && 32'(ra2) < NUM_REGS)
            rd2 = (we && wa == ra2) ? wd : regs[ra2[RA_W-1:0]];
    end

endmodule

// File: rtl/decode_stage_v2.sv
// rtl/decode_stage_v2.sv - RV32I/E decode stage with WB bypass, load-use interlock and ID/EX handshake
module decode_stage_v2
    import decode_stage_v2_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          NUM_REGS     = 32,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    decode_stage_v2_if.slave             bus,
    input  logic [IMM_SEL_WIDTH-1:0]     imm_sel,
    input  logic [BRANCH_OP_WIDTH-1:0]   br_op,
    input  logic [FORWARD_SEL_WIDTH-1:0] br_a_sel,
    input  logic [FORWARD_SEL_WIDTH-1:0] br_b_sel,
    input  logic [XLEN-1:0]              fwd_mem,
    input  logic [XLEN-1:0]              fwd_wb,
    input  logic                         wb_en,
    input  logic [4:0]                   wb_rd,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         exe_mem_read,
    input  logic [4:0]                   exe_rd,
    input  logic                         flush,
    output logic [XLEN-1:0]              br_target,
    output logic [XLEN-1:0]              jal_target,
    output logic [XLEN-1:0]              jalr_target,
    output logic                         br_taken,
    output logic                         load_use_stall,
    output logic [CNT_W-1:0]             stall_count
);

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    reg_idx_t        rs1, rs2, rd;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic [XLEN-1:0] br_a, br_b;
    logic [XLEN-1:0] jalr_sum;
    logic            cmp_taken;
    logic            hz, adv, illegal;

    assign rs1 = rs1_of(bus.in_instr);
    assign rs2 = rs2_of(bus.in_instr);
    assign rd  = rd_of(bus.in_instr);

    regfile_param #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rf_rs1),
        .rd2 (rf_rs2),
        .we  (wb_en),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    always_comb begin
        br_a = rf_rs1;
        case (br_a_sel)
            FORWARD_SEL_MEM: br_a = fwd_mem;
            FORWARD_SEL_WB:  br_a = fwd_wb;
            default:         br_a = rf_rs1;
        endcase
    end

    always_comb begin
        br_b = rf_rs2;
        case (br_b_sel)
            FORWARD_SEL_MEM: br_b = fwd_mem;
            FORWARD_SEL_WB:  br_b = fwd_wb;
            default:         br_b = rf_rs2;
        endcase
    end

    branch_comp #(.XLEN(XLEN)) u_branch_comp (
        .op    (br_op),
        .a     (br_a),
        .b     (br_b),
        .taken (cmp_taken)
    );

    assign br_taken    = bus.in_valid && cmp_taken;
    assign br_target   = bus.in_pc + sext(imm_b(bus.in_instr));
    assign jal_target  = bus.in_pc + sext(imm_j(bus.in_instr));
    assign jalr_sum    = br_a + sext(imm_i(bus.in_instr));
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

    assign hz = bus.in_valid && exe_mem_read && (exe_rd != 5'd0) &&
                ((exe_rd == rs1) || (exe_rd == rs2));
    assign load_use_stall = hz;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv && !hz && !flush;
    assign illegal      = (32'(rs1) >= NUM_REGS) || (32'(rs2) >= NUM_REGS) || (32'(rd) >= NUM_REGS);

    // A bubble leaves data fields as they were; only validity, instruction and indices are scrubbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid       <= 1'b0;
            bus.out_pc          <= '0;
            bus.out_rs1_data    <= '0;
            bus.out_rs2_data    <= '0;
            bus.out_imm         <= '0;
            bus.out_instr       <= BUBBLE_INSTR;
            bus.out_rs1_addr    <= '0;
            bus.out_rs2_addr    <= '0;
            bus.out_rd_addr     <= '0;
            bus.out_illegal_reg <= 1'b0;
        end else if (flush || (adv && hz)) begin
            bus.out_valid    <= 1'b0;
            bus.out_instr    <= BUBBLE_INSTR;
            bus.out_rs1_addr <= '0;
            bus.out_rs2_addr <= '0;
            bus.out_rd_addr  <= '0;
        end else if (adv && bus.in_valid) begin
            bus.out_valid       <= 1'b1;
            bus.out_pc          <= bus.in_pc;
            bus.out_rs1_data    <= rf_rs1;
            bus.out_rs2_data    <= rf_rs2;
            bus.out_imm         <= sext(gen_imm(bus.in_instr, imm_sel));
            bus.out_instr       <= bus.in_instr;
            bus.out_rs1_addr    <= rs1;
            bus.out_rs2_addr    <= rs2;
            bus.out_rd_addr     <= rd;
            bus.out_illegal_reg <= illegal;
        end else if (adv) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (hz && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: doc/decode_stage_v2.md
Name: decode_stage_v2

Overview:
Parametrised successor to the single-issue RV32I decode stage. Sits between the IF/ID register and execute. It reads the register file with WB bypass, generates immediates and early branch/jump targets, and registers results into an ID/EX register guarded by a valid/ready handshake. Adds a load-use interlock, backpressure, a configurable register count (RV32I/RV32E), an illegal-register flag, and a saturating stall counter.

Parameters:
XLEN, 32, datapath width
NUM_REGS, 32, architectural registers (32 or 16); RA_W = $clog2(NUM_REGS)
CNT_W, 16, width of the load-use stall counter
BUBBLE_INSTR, 32'h0000_0013, instruction word driven when the stage inserts a bubble

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts IF/ID this cycle
in_pc  in  XLEN  PC of the IF/ID instruction
in_instr  in  32  IF/ID instruction
imm_sel  in  IMM_SEL_WIDTH  immediate format, from control
br_op  in  BRANCH_OP_WIDTH  branch comparison op
br_a_sel, br_b_sel  in  FORWARD_SEL_WIDTH  branch operand forward selects (EXE=regfile, MEM, WB)
fwd_mem, fwd_wb  in  XLEN  forwarded values
wb_en  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
exe_mem_read  in  1  instruction in EXE is a load
exe_rd  in  5  destination of the instruction in EXE
flush  in  1  kill the decode and ID/EX contents
out_valid  out  1  ID/EX holds a valid instruction
out_ready  in  1  execute accepts ID/EX
out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  ID/EX payload
out_instr  out  32  ID/EX instruction
out_rs1_addr, out_rs2_addr, out_rd_addr  out  5  register indices
out_illegal_reg  out  1  an index was out of range for NUM_REGS
br_target, jal_target, jalr_target  out  XLEN  combinational targets
br_taken  out  1  combinational branch compare result
load_use_stall  out  1  interlock is active this cycle
stall_count  out  CNT_W  saturating count of interlock cycles

Behaviour:
- Reset (async, rst=1): out_valid=0, all payload outputs 0, out_instr=BUBBLE_INSTR, stall_count=0, register file cleared.
- Definitions: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- Hazard: hz = in_valid && exe_mem_read && exe_rd!=0 && (exe_rd==rs1 || exe_rd==rs2). load_use_stall = hz.
- Downstream free: adv = !out_valid || out_ready.
- in_ready = adv && !hz && !flush.
- Register update, in priority order:
  1. flush: out_valid<=0, out_instr<=BUBBLE_INSTR, all address fields 0.
  2. adv && hz: bubble (same as flush); the IF/ID instruction is not consumed.
  3. adv && in_valid: load the payload and set out_valid<=1.
  4. adv && !in_valid: out_valid<=0.
  5. Otherwise (!adv): hold every output unchanged.
- Latency: 1 cycle from acceptance to out_valid.
- Register file: NUM_REGS x XLEN, written on the rising edge when wb_en && wb_rd!=0 && wb_rd<NUM_REGS. x0 reads 0.
- Read bypass: if wb_en && wb_rd!=0 && wb_rd==rsN, the read returns wb_data in the same cycle. This bypass feeds both the ID/EX data and the branch operands selected by EXE.
- out_illegal_reg is captured with the payload: set when any of rs1/rs2/rd is >= NUM_REGS. Out-of-range indices read 0.
- Immediates use RV32 I/S/B/J/U formats; an unknown imm_sel falls back to I.
- Targets: jal_target = in_pc + J-imm; br_target = in_pc + B-imm; jalr_target = (rs1 operand + I-imm) & ~1. All arithmetic wraps modulo 2^XLEN.
- br_taken is evaluated on the forwarded operands and is forced to 0 when !in_valid.
- stall_count increments on each cycle with hz=1, saturates at 2^CNT_W-1, and is unaffected by flush.
- Simultaneous WB write and read of the same register: the read returns the new value.
- rst asserted mid-stall: all state clears immediately; no handshake survives reset.

Decomposition:
- Shared package (constants.vh/pkg): IMM_SEL_*, BRANCH_OP_*, FORWARD_SEL_* encodings, BUBBLE_INSTR default, and the instruction field-slice constants.
- Sub-module regfile_param (NUM_REGS, XLEN): 2 read ports, 1 write port, async active-high reset, internal bypass.
- branch_comp is reused unchanged.

Test Plan:
- Reset, then instr 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, out_imm=5, out_rd_addr=1, out_pc=0x100.
- exe_mem_read=1, exe_rd=2; decode instr add x3,x2,x1 -> load_use_stall=1, in_ready=0, next out_instr=0x00000013 with out_valid=0, stall_count=1. Drop exe_mem_read -> instruction issues on the following cycle.
- out_ready=0 for 3 cycles while out_valid=1 -> all outputs stable, in_ready=0. Raise out_ready -> the next instruction issues.
- Same cycle: wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; decode rs1=5 -> out_rs1_data=0xDEADBEEF. With wb_rd=0 instead -> out_rs1_data=0.
- NUM_REGS=16; decode instr with rs2=17 -> out_illegal_reg=1, out_rs2_data=0. Write to x20 -> register file unchanged.
- Hold hz for 2^CNT_W+3 cycles with CNT_W=4 -> stall_count=15. flush during hz -> out_valid=0 and stall_count is still counted.
